// File: rtl/board_update_ctrl.sv
// Chess board state owner: accepts one move at a time and commits it only during vertical blanking.
// Optional MOVE_COUNTER_EN builds a saturating half-move counter on move_cnt.
module board_update_ctrl #(
    parameter int PIECE_W = 4,
    parameter int CNT_W   = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vblank,
    input  logic                   new_game,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [5:0]             req_src,
    input  logic [5:0]             req_dst,
    output logic [64*PIECE_W-1:0]  board_flat,
    output logic                   done,
    output logic                   err,
    output logic [PIECE_W-1:0]     captured,
    output logic [CNT_W-1:0]       move_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VBL,
        S_APPLY,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [63:0][PIECE_W-1:0]   r_board;
    logic [5:0]                 r_src;
    logic [5:0]                 r_dst;
    logic                       r_err;
    logic [PIECE_W-1:0]         r_captured;
    logic [PIECE_W-1:0]         w_src_code;
    logic [PIECE_W-1:0]         w_dst_code;
    logic                       w_err;
    logic                       w_accept;
    logic                       w_commit;

    function automatic logic [63:0][PIECE_W-1:0] start_board();
        logic [63:0][PIECE_W-1:0] b;
        logic [2:0]               t;
        b = '0;
        for (int unsigned c = 0; c < 8; c++) begin
            case (c)
                0, 7:    t = 3'd4;
                1, 6:    t = 3'd2;
                2, 5:    t = 3'd3;
                3:       t = 3'd5;
                default: t = 3'd6;
            endcase
            b[6'(c)][3]        = 1'b1;
            b[6'(c)][2:0]      = t;
            b[6'(8 + c)][3:0]  = 4'h9;
            b[6'(48 + c)][3:0] = 4'h1;
            b[6'(56 + c)][2:0] = t;
        end
        return b;
    endfunction

    assign w_src_code = r_board[r_src];
    assign w_dst_code = r_board[r_dst];
    assign w_err      = (w_src_code == '0) || (r_src == r_dst) ||
                        ((w_dst_code != '0) && (w_dst_code[3] == w_src_code[3]));
    assign w_accept   = (r_state == S_IDLE) && req_valid && !new_game;
    assign w_commit   = (r_state == S_APPLY) && !new_game;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (req_valid) w_next = S_WAIT_VBL;
            S_WAIT_VBL: if (vblank)    w_next = S_APPLY;
            S_APPLY:    w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        if (new_game) begin
            w_next = S_IDLE;
        end
    end

    always_comb begin
        req_ready = (r_state == S_IDLE) && !new_game;
        done      = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src <= '0;
            r_dst <= '0;
        end else if (w_accept) begin
            r_src <= req_src;
            r_dst <= req_dst;
        end
    end

    // new_game outranks an in-flight commit, so a move in APPLY is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_board <= start_board();
        end else if (new_game) begin
            r_board <= start_board();
        end else if (w_commit && !w_err) begin
            r_board[r_dst] <= w_src_code;
            r_board[r_src] <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_captured <= '0;
        end else if (w_commit) begin
            r_err      <= w_err;
            r_captured <= w_err ? '0 : w_dst_code;
        end
    end

`ifdef MOVE_COUNTER_EN
    logic [CNT_W-1:0] r_move_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_move_cnt <= '0;
        end else if (new_game) begin
            r_move_cnt <= '0;
        end else if (w_commit && !w_err && (r_move_cnt != '1)) begin
            r_move_cnt <= r_move_cnt + 1'b1;
        end
    end

    assign move_cnt = r_move_cnt;
`else
    assign move_cnt = '0;
`endif

    assign board_flat = r_board;
    assign err        = r_err;
    assign captured   = r_captured;

endmodule

// File: tb/tb_board_update_ctrl.sv
// Scoreboard bench for board_update_ctrl: a board-array reference model queues expected results per move.
module tb_board_update_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         vblank = 1'b0;
    logic         new_game = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [5:0]   req_src = '0;
    logic [5:0]   req_dst = '0;
    logic [255:0] board_flat;
    logic         done;
    logic         err;
    logic [3:0]   captured;
    logic [9:0]   move_cnt;

    board_update_ctrl #(.PIECE_W(4), .CNT_W(10)) dut (
        .clk(clk), .reset(reset), .vblank(vblank), .new_game(new_game),
        .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src), .req_dst(req_dst),
        .board_flat(board_flat), .done(done), .err(err), .captured(captured), .move_cnt(move_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         e;
        logic [3:0]   cap;
        logic [255:0] brd;
        int unsigned  cnt;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  mb[64];
    int unsigned mcnt;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 64; i++) f[i*4 +: 4] = mb[i];
        return f;
    endfunction

    function automatic void model_reset();
        int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        for (int i = 0; i < 64; i++) mb[i] = 4'h0;
        for (int c = 0; c < 8; c++) begin
            mb[c]      = 4'(8 + back[c]);
            mb[8 + c]  = 4'h9;
            mb[48 + c] = 4'h1;
            mb[56 + c] = 4'(back[c]);
        end
        mcnt = 0;
    endfunction

    function automatic void model_move(input int s, input int d);
        exp_t x;
        bit   bad;
        bad = (mb[s] == 0) || (s == d) || (mb[d] != 0 && mb[d][3] == mb[s][3]);
        x.e = bad;
        x.cap = bad ? 4'h0 : mb[d];
        if (!bad) begin
            mb[d] = mb[s];
            mb[s] = 4'h0;
`ifdef MOVE_COUNTER_EN
            if (mcnt < 1023) mcnt++;
`endif
        end
        x.brd = model_flat();
        x.cnt = mcnt;
        q.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending move");
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("err", err, x.e);
                chk("captured", captured, x.cap);
                chk("board", board_flat, x.brd);
                chk("move_cnt", move_cnt, x.cnt);
            end
        end
    end

    task automatic handshake(input logic [5:0] s, input logic [5:0] d, input bit vb);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", req_ready, 1);
        vblank    = vb;
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_src   = 6'($urandom);
        req_dst   = 6'($urandom);
    endtask

    task automatic do_move(input logic [5:0] s, input logic [5:0] d, input int hold_low, input bit detail);
        logic [255:0] prev;
        int n;
        prev = model_flat();
        handshake(s, d, hold_low == 0);
        model_move(s, d);
        for (int i = 0; i < hold_low; i++) begin
            @(negedge clk);
            if (detail) begin
                chk("wait_ready", req_ready, 0);
                chk("wait_board", board_flat, prev);
            end
        end
        vblank = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        if (done !== 1'b1) chk("done_timeout", done, 1);
        else chk("latency", n, (hold_low > 0) ? 2 : 3);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("ready_after", req_ready, 1);
    endtask

    task automatic no_done(input int cycles);
        bit seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        chk("no_done", seen, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_sq4", board_flat[4*4 +: 4], 4'hE);
        chk("rst_sq60", board_flat[60*4 +: 4], 4'h6);
        chk("rst_sq36", board_flat[36*4 +: 4], 4'h0);
        chk("rst_board", board_flat, model_flat());
        chk("rst_ready", req_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_captured", captured, 0);
        chk("rst_move_cnt", move_cnt, 0);

        do_move(52, 36, 0, 1);
        do_move(12, 28, 100, 1);
        do_move(11, 27, 0, 1);
        do_move(36, 27, 0, 1);
        do_move(20, 28, 0, 1);
        do_move(60, 60, 2, 1);
        do_move(63, 55, 0, 1);

        // Drop an outstanding request with new_game, and refuse a request coincident with it.
        handshake(52, 44, 0);
        repeat (3) @(negedge clk);
        new_game  = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        new_game  = 1'b0;
        req_valid = 1'b0;
        vblank    = 1'b1;
        model_reset();
        @(negedge clk);
        chk("ng_ready", req_ready, 1);
        chk("ng_board", board_flat, model_flat());
        chk("ng_move_cnt", move_cnt, 0);
        no_done(6);
        new_game  = 1'b1;
        req_valid = 1'b1;
        req_src   = 52;
        req_dst   = 36;
        #1;
        chk("ng_ready_forced", req_ready, 0);
        @(posedge clk);
        #1;
        new_game  = 1'b0;
        req_valid = 1'b0;
        no_done(6);
        chk("ng_no_accept", board_flat, model_flat());

        do_move(52, 36, 0, 1);
        handshake(51, 43, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_board", board_flat, model_flat());
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        reset  = 1'b0;
        vblank = 1'b1;
        no_done(5);

        for (int k = 0; k < 80; k++) begin
            int s;
            int d;
            s = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) begin
                for (int t = 0; t < 64 && mb[s] == 0; t++) s = $urandom_range(0, 63);
            end
            d = ($urandom_range(0, 9) == 0) ? s : $urandom_range(0, 63);
            do_move(6'(s), 6'(d), $urandom_range(0, 3), 0);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
